// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//   Bundles the instruction fields, ALU flags and memory handshake going into
//   the multicycle control FSM together with every control strobe and select
//   it drives back into the shared datapath.
//
//   master : datapath / IR side. Drives Cond, Op, Funct, Rd, ALUFlags and
//            MemReady, and observes the control outputs.
//   slave  : controller side. The inverse of master.
//
//   Signals
//     Cond[3:0]  Instr[31:28]        Op[1:0]     Instr[27:26]
//     Funct[5:0] Instr[25:20]        Rd[3:0]     Instr[15:12]
//     ALUFlags   NZCV from the ALU   MemReady    memory done
//     PCWrite AdrSrc MemW IRWrite RegW ResultSrc ALUSrcA ALUSrcB
//     ALUControl ImmSrc RegSrc Undef State(debug)
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemW;
  logic       IRWrite;
  logic       RegW;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       Undef;
  logic [3:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle ARMv4 core. Steps one shared ALU/memory
//   datapath through fetch, decode, execute and writeback, decodes the ALU
//   operation from Funct, evaluates the condition field against an internal
//   NZCV register and gates every architectural write with the result.
//
//   Ports
//     clk    core clock, all state changes on the rising edge
//     rst_n  asynchronous active-low reset (FETCH, flags cleared, strobes low)
//     bus    multicycle_controller_if.slave: instruction fields, ALUFlags,
//            MemReady in; control strobes/selects and debug State out
//
//   Parameters
//     STATE_W  state register width (10 of 16 encodings used)
//
//   Optional feature
//     CTRL_MEM_WAIT_EN  when defined, FETCH, MEMRD and MEMWR hold until
//                       MemReady=1. Undefined: every state lasts one cycle
//                       and MemReady is ignored.
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.slave  bus
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         flags_q, flags_d;
  logic               cond_ex;
  logic               no_write;
  logic [1:0]         alu_ctrl;
  logic               mem_rdy;
  logic               n_f, z_f, c_f, v_f;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_rdy = bus.MemReady;
`else
  logic unused_mem_ready;
  assign mem_rdy          = 1'b1;
  assign unused_mem_ready = bus.MemReady;
`endif

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition check always uses the registered flags, so an S-instruction's
  // own flag update is already visible to its ALUWB cycle.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU operation from Funct[4:1]; only data-processing states decode it,
  // everything else (PC+4, PC+8, address and branch target) is an ADD.
  always_comb begin
    alu_ctrl = ALU_ADD;
    no_write = 1'b0;
    if (state_q inside {S_EXECR, S_EXECI, S_ALUWB}) begin
      case (bus.Funct[4:1])
        4'b0100: alu_ctrl = ALU_ADD;
        4'b0010: alu_ctrl = ALU_SUB;
        4'b0000: alu_ctrl = ALU_AND;
        4'b1100: alu_ctrl = ALU_ORR;
        4'b1010: begin
          alu_ctrl = ALU_SUB;
          no_write = 1'b1;
        end
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end

  // Flags are captured in the cycle the ALU computes the result. C and V are
  // only meaningful for the arithmetic ops (ADD/SUB, CMP included).
  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex && bus.Funct[0]) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
      if (!alu_ctrl[1])
        flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while rst_n is asserted because the reset state
  // (FETCH) would otherwise load PC and IR.
  always_comb begin
    logic pc_write, mem_w, ir_write, reg_w, undef;
    pc_write       = 1'b0;
    mem_w          = 1'b0;
    ir_write       = 1'b0;
    reg_w          = 1'b0;
    undef          = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write      = mem_rdy;
        pc_write      = mem_rdy;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        undef       = (bus.Op == 2'b11);
      end
      S_MEMADR: bus.ALUSrcB = 2'b01;
      S_MEMRD:  bus.AdrSrc  = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_w         = cond_ex;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        mem_w      = cond_ex;
      end
      S_EXECR:  bus.ALUSrcB = 2'b00;
      S_EXECI:  bus.ALUSrcB = 2'b01;
      S_ALUWB: begin
        reg_w    = cond_ex & ~no_write;
        pc_write = cond_ex & ~no_write & (bus.Rd == 4'd15);
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_write      = cond_ex;
      end
      default: ;
    endcase
    bus.PCWrite    = rst_n & pc_write;
    bus.MemW       = rst_n & mem_w;
    bus.IRWrite    = rst_n & ir_write;
    bus.RegW       = rst_n & reg_w;
    bus.Undef      = rst_n & undef;
    bus.ALUControl = alu_ctrl;
    bus.ImmSrc     = bus.Op;
    bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    bus.State      = state_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Instruction-level reference model: each instruction is expanded into the
//   list of per-cycle control vectors it must produce, pushed to a queue as
//   the stimulus is applied; a monitor pops one entry per cycle on the
//   falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic       undef;
    logic [3:0] st;
  } ov_t;

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ov_t   exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  // Instruction currently presented by the IR, plus model state.
  logic [3:0] cur_cond, cur_rd, cur_af;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  string      cur_tag;
  logic [3:0] m_flags;

  // ---------------- monitor ----------------
  initial begin
    ov_t   e, act;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = {bus.PCWrite, bus.AdrSrc, bus.MemW, bus.IRWrite, bus.RegW,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
               bus.ImmSrc, bus.RegSrc, bus.Undef, bus.State};
        n_checks++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b srca=%b srcb=%b aluc=%b imm=%b regsrc=%b undef=%b st=%0d, expected pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b srca=%b srcb=%b aluc=%b imm=%b regsrc=%b undef=%b st=%0d",
                   t, act.pcw, act.adr, act.memw, act.irw, act.regw, act.res, act.srca,
                   act.srcb, act.aluc, act.imm, act.regsrc, act.undef, act.st,
                   e.pcw, e.adr, e.memw, e.irw, e.regw, e.res, e.srca,
                   e.srcb, e.aluc, e.imm, e.regsrc, e.undef, e.st);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;                       // EQ
      4'h1: return !z;                      // NE
      4'h2: return cy;                      // CS
      4'h3: return !cy;                     // CC
      4'h4: return n;                       // MI
      4'h5: return !n;                      // PL
      4'h6: return v;                       // VS
      4'h7: return !v;                      // VC
      4'h8: return cy && !z;                // HI
      4'h9: return !cy || z;                // LS
      4'hA: return n == v;                  // GE
      4'hB: return n != v;                  // LT
      4'hC: return !z && (n == v);          // GT
      4'hD: return z || (n != v);           // LE
      4'hE: return 1'b1;                    // AL
      default: return 1'b0;
    endcase
  endfunction

  function automatic ov_t base_v(input int st);
    ov_t e = '0;
    e.imm    = cur_op;
    e.regsrc = {cur_op == 2'b01, cur_op == 2'b10};
    e.st     = 4'(st);
    return e;
  endfunction

  function automatic ov_t fetch_v();
    ov_t e = base_v(0);
    e.irw = 1'b1; e.pcw = 1'b1; e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
    return e;
  endfunction

  // mr: 0/1 drive MemReady to that value, 2 drive a random value.
  task automatic step(input ov_t e, input int mr, input bit rst);
    @(posedge clk);
    #1;
    rst_n        = rst;
    bus.Cond     = cur_cond;
    bus.Op       = cur_op;
    bus.Funct    = cur_funct;
    bus.Rd       = cur_rd;
    bus.ALUFlags = cur_af;
    bus.MemReady = (mr == 2) ? 1'($urandom_range(0, 1)) : 1'(mr);
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [3:0] af, input string tag);
    cur_cond  = ins[31:28];
    cur_op    = ins[27:26];
    cur_funct = ins[25:20];
    cur_rd    = ins[15:12];
    cur_af    = af;
    cur_tag   = tag;
  endtask

  task automatic reset_cycles(input int n);
    ov_t e;
    for (int i = 0; i < n; i++) begin
      e = fetch_v();
      e.irw = 1'b0;
      e.pcw = 1'b0;
      step(e, 2, 1'b0);
    end
    m_flags = 4'b0000;
  endtask

  task automatic do_fetch(input int w);
    ov_t e, s;
    e = fetch_v();
    if (WAIT_EN) begin
      s = e; s.irw = 1'b0; s.pcw = 1'b0;
      for (int i = 0; i < w; i++) step(s, 0, 1'b1);
      step(e, 1, 1'b1);
    end else begin
      step(e, 2, 1'b1);
    end
  endtask

  task automatic do_mem_wait(input ov_t e, input int w);
    if (WAIT_EN) begin
      for (int i = 0; i < w; i++) step(e, 0, 1'b1);
      step(e, 1, 1'b1);
    end else begin
      step(e, 2, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int w,
                           input string tag);
    ov_t        e;
    logic [1:0] aluc;
    logic       nw, p;
    set_instr(ins, af, tag);
    do_fetch(w);
    e = base_v(1); e.srca = 1'b1; e.srcb = 2'b10; e.undef = (cur_op == 2'b11);
    step(e, 2, 1'b1);
    case (cur_op)
      2'b00: begin
        nw = 1'b0;
        case (cur_funct[4:1])
          4'b0010: aluc = 2'b01;
          4'b0000: aluc = 2'b10;
          4'b1100: aluc = 2'b11;
          4'b1010: begin aluc = 2'b01; nw = 1'b1; end
          default: aluc = 2'b00;
        endcase
        e = base_v(cur_funct[5] ? 7 : 6);
        e.srcb = cur_funct[5] ? 2'b01 : 2'b00;
        e.aluc = aluc;
        step(e, 2, 1'b1);
        if (cond_pass(cur_cond, m_flags) && cur_funct[0]) begin
          m_flags[3:2] = af[3:2];
          if (aluc == 2'b00 || aluc == 2'b01) m_flags[1:0] = af[1:0];
        end
        p = cond_pass(cur_cond, m_flags);
        e = base_v(8);
        e.aluc = aluc;
        e.regw = p && !nw;
        e.pcw  = p && !nw && (cur_rd == 4'd15);
        step(e, 2, 1'b1);
      end
      2'b01: begin
        p = cond_pass(cur_cond, m_flags);
        e = base_v(2); e.srcb = 2'b01;
        step(e, 2, 1'b1);
        if (cur_funct[0]) begin
          e = base_v(3); e.adr = 1'b1;
          do_mem_wait(e, w);
          e = base_v(4); e.res = 2'b01; e.regw = p;
          step(e, 2, 1'b1);
        end else begin
          e = base_v(5); e.adr = 1'b1; e.memw = p;
          do_mem_wait(e, w);
        end
      end
      2'b10: begin
        e = base_v(9); e.srcb = 2'b01; e.res = 2'b10;
        e.pcw = cond_pass(cur_cond, m_flags);
        step(e, 2, 1'b1);
      end
      default: ;
    endcase
  endtask

  // LDR abandoned in MEMRD by an asynchronous reset.
  task automatic run_abort();
    ov_t e;
    set_instr(32'hE5910004, 4'h0, "ldr_abort");
    do_fetch(0);
    e = base_v(1); e.srca = 1'b1; e.srcb = 2'b10;
    step(e, 2, 1'b1);
    e = base_v(2); e.srcb = 2'b01;
    step(e, 2, 1'b1);
    e = base_v(3); e.adr = 1'b1;
    step(e, 0, 1'b1);
    cur_tag = "reset_mid";
    reset_cycles(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ins;
    cur_cond = 4'h0; cur_op = 2'b00; cur_funct = 6'h0; cur_rd = 4'h0; cur_af = 4'h0;
    cur_tag = "reset"; m_flags = 4'b0000;
    rst_n = 1'b0;
    bus.Cond = 4'h0; bus.Op = 2'b00; bus.Funct = 6'h0; bus.Rd = 4'h0;
    bus.ALUFlags = 4'h0; bus.MemReady = 1'b1;

    reset_cycles(3);

    run_instr(32'hE0821003, 4'h0, 0, "add");
    run_instr(32'hE5910004, 4'h0, 0, "ldr");
    run_instr(32'hE5810004, 4'h0, 0, "str");
    run_instr(32'hE0500000, 4'b0100, 0, "subs");
    run_instr(32'h10821003, 4'b1011, 0, "addne_fail");
    run_instr(32'h00821003, 4'b0000, 0, "addeq_pass");
    run_instr(32'hEA000002, 4'h0, 0, "b");
    run_instr(32'hE7F000F0, 4'h0, 0, "undef");
    run_instr(32'hE082F003, 4'h0, 0, "add_pc");
    run_instr(32'hE1510002, 4'b1001, 0, "cmp");
    run_instr(32'hA0821003, 4'h0, 0, "addge_pass");
    run_instr(32'hB0821003, 4'h0, 0, "addlt_fail");
    run_instr(32'hE1100002, 4'b1111, 0, "cmp_nos");
    run_instr(32'hB082F003, 4'h0, 0, "addlt_pc_fail");
    run_instr(32'hF0821003, 4'h0, 0, "nv_cond");
    run_instr(32'hE0821003, 4'h0, 3, "add_fetch_wait3");
    run_instr(32'hE5910004, 4'h0, 2, "ldr_wait");
    run_instr(32'hE5810004, 4'h0, 2, "str_wait");

    run_instr(32'hE0500000, 4'b0100, 0, "subs2");
    run_abort();
    run_instr(32'h00821003, 4'h0, 0, "addeq_after_reset");
    run_instr(32'h10821003, 4'h0, 0, "addne_after_reset");

    for (int i = 0; i < 200; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      if ($urandom_range(0, 2) == 0) ins[26:21] = 6'($urandom_range(0, 1) ? 5'b01010 : 5'b00100);
      run_instr(ins, 4'($urandom), $urandom_range(0, 2), $sformatf("rnd%0d_%h", i, ins));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

endmodule
